// File: rtl/bus_sel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sel_arbiter_pkg
//  Description : Shared constants, channel encoding and output FSM states for
//                the bus_sel_arbiter feeder stage.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_sel_arbiter_pkg;

    // Default data width of each channel and output operand bus
    localparam int DEF_WIDTH = 4;

    // Channel encoding, doubles as the out_sel value driven to the mux
    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    // Output register state: EMPTY = no valid operand pair, HOLD = presenting
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_e;

    // Saturating 16-bit increment used by the handshake statistics
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_sel_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sel_arbiter_if
//  Description : Bundle of the two input valid/ready nibble streams and the
//                registered operand/select output handshake.
//                slave  = arbiter side, master = producer/consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_sel_arbiter_if
    import bus_sel_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_sel;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_a, out_b, out_sel
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_a, out_b, out_sel
    );

endinterface
`default_nettype wire

// File: rtl/bus_sel_arbiter_sel_chan_buf.sv
`default_nettype none
// ============================================================================
//  Module      : sel_chan_buf
//  Description : One-entry input buffer with full flag. Ready is asserted when
//                empty or when the entry is being drained this cycle, so a
//                drain and refill can share the same edge.
//  Revision    : 1.0  initial release
// ============================================================================
module sel_chan_buf
    import bus_sel_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             drain,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             take;

    // Ready / fill / drain decision; ready is held low while in reset
    always_comb begin
        in_ready = rst_n && (!full_q || drain);
        take     = in_valid && in_ready;
        full_d   = full_q;
        data_d   = data_q;
        if (take) begin
            full_d = 1'b1;
            data_d = in_data;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/bus_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sel_arbiter
//  Description : Buffers two nibble streams, arbitrates fairly with a bounded
//                burst on contention and presents a registered operand pair
//                plus select bit to the downstream 2:1 mux.
//                Optional macro BUS_SEL_STATS_EN adds per-channel handshake
//                counters cnt_a/cnt_b with synchronous clear stats_clr.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_sel_arbiter
    import bus_sel_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BURST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_sel_arbiter_if.slave bus
`ifdef BUS_SEL_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
`endif
);

    localparam logic [3:0] BURST_LIM = 4'(BURST);

    logic             a_full, b_full;
    logic [WIDTH-1:0] a_buf, b_buf;
    logic             grant_a, grant_b, load;

    out_state_e       state_q, state_d;
    logic             pref_q, pref_d;
    logic [3:0]       burst_cnt_q, burst_cnt_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic             out_sel_q, out_sel_d;

    sel_chan_buf #(.WIDTH(WIDTH)) u_buf_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.a_valid),
        .in_data  (bus.a_data),
        .in_ready (bus.a_ready),
        .drain    (grant_a),
        .full     (a_full),
        .data     (a_buf)
    );

    sel_chan_buf #(.WIDTH(WIDTH)) u_buf_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (bus.b_valid),
        .in_data  (bus.b_data),
        .in_ready (bus.b_ready),
        .drain    (grant_b),
        .full     (b_full),
        .data     (b_buf)
    );

    // Arbitration, burst accounting and output next-state
    always_comb begin
        state_d     = state_q;
        pref_d      = pref_q;
        burst_cnt_d = burst_cnt_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_sel_d   = out_sel_q;

        load    = (state_q == ST_EMPTY) || bus.out_ready;
        grant_a = load && a_full && (!b_full || (pref_q == CH_A));
        grant_b = load && b_full && (!a_full || (pref_q == CH_B));

        if (load) begin
            if (grant_a) begin
                state_d   = ST_HOLD;
                out_a_d   = a_buf;
                out_sel_d = CH_A;
            end else if (grant_b) begin
                state_d   = ST_HOLD;
                out_b_d   = b_buf;
                out_sel_d = CH_B;
            end else begin
                state_d   = ST_EMPTY;
            end

            // Only contended grants count toward the burst limit
            if (a_full && b_full) begin
                if (burst_cnt_q + 4'd1 == BURST_LIM) begin
                    pref_d      = ~pref_q;
                    burst_cnt_d = 4'd0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
            end
        end
    end

    // Output register, FSM state and fairness state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            pref_q      <= CH_A;
            burst_cnt_q <= 4'd0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_sel_q   <= CH_A;
        end else begin
            state_q     <= state_d;
            pref_q      <= pref_d;
            burst_cnt_q <= burst_cnt_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_sel   = out_sel_q;

`ifdef BUS_SEL_STATS_EN
    logic [15:0] cnt_a_q, cnt_a_d;
    logic [15:0] cnt_b_q, cnt_b_d;

    // Per-channel output handshake counters; clear wins over increment
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (stats_clr) begin
            cnt_a_d = 16'd0;
            cnt_b_d = 16'd0;
        end else if ((state_q == ST_HOLD) && bus.out_ready) begin
            if (out_sel_q == CH_A) cnt_a_d = sat_inc16(cnt_a_q);
            else                   cnt_b_d = sat_inc16(cnt_b_q);
        end
    end

    // Counter storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= 16'd0;
            cnt_b_q <= 16'd0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_sel_arbiter
//  Description : Self-checking bench for bus_sel_arbiter. Lane 0 uses BURST=1,
//                lane 1 uses BURST=2. Cycle vector table plus scoreboard-based
//                contention/backpressure streams, mid-operation reset and the
//                optional statistics counters (BUS_SEL_STATS_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_sel_arbiter;
    import bus_sel_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Lane-indexed drive and observe signals
    logic       av[2], bv[2], ordy[2];
    logic [3:0] ad[2], bd[2];
    logic       ar[2], br[2], ov[2], sel[2];
    logic [3:0] oa[2], ob[2];

    bus_sel_arbiter_if #(.WIDTH(4)) if0 ();
    bus_sel_arbiter_if #(.WIDTH(4)) if1 ();

    assign if0.a_valid = av[0];   assign if1.a_valid = av[1];
    assign if0.a_data  = ad[0];   assign if1.a_data  = ad[1];
    assign if0.b_valid = bv[0];   assign if1.b_valid = bv[1];
    assign if0.b_data  = bd[0];   assign if1.b_data  = bd[1];
    assign if0.out_ready = ordy[0]; assign if1.out_ready = ordy[1];
    assign ar[0] = if0.a_ready;   assign ar[1] = if1.a_ready;
    assign br[0] = if0.b_ready;   assign br[1] = if1.b_ready;
    assign ov[0] = if0.out_valid; assign ov[1] = if1.out_valid;
    assign sel[0] = if0.out_sel;  assign sel[1] = if1.out_sel;
    assign oa[0] = if0.out_a;     assign oa[1] = if1.out_a;
    assign ob[0] = if0.out_b;     assign ob[1] = if1.out_b;

`ifdef BUS_SEL_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] cnt_a0, cnt_b0, cnt_a1, cnt_b1;
`endif

    bus_sel_arbiter #(.WIDTH(4), .BURST(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
`ifdef BUS_SEL_STATS_EN
        , .stats_clr (stats_clr), .cnt_a (cnt_a0), .cnt_b (cnt_b0)
`endif
    );

    bus_sel_arbiter #(.WIDTH(4), .BURST(2)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
`ifdef BUS_SEL_STATS_EN
        , .stats_clr (stats_clr), .cnt_a (cnt_a1), .cnt_b (cnt_b1)
`endif
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        for (int l = 0; l < 2; l++) begin
            av[l] = 1'b0; ad[l] = 4'h0; bv[l] = 1'b0; bd[l] = 4'h0; ordy[l] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] a_val(input int i);
        return 4'(2 * i + 1);
    endfunction

    function automatic logic [3:0] b_val(input int i);
        return 4'(2 * i + 2);
    endfunction

    // Cycle vector: inputs, readies before the edge, outputs after the edge
    typedef struct {
        logic av; logic [3:0] ad; logic bv; logic [3:0] bd; logic ordy;
        logic ar; logic br;
        logic ov; logic sel; logic [3:0] oa; logic [3:0] ob;
    } vec_t;

    vec_t vt[13];

    // Scoreboard of expected {sel, data} in grant order
    logic [4:0] sbq[$];

    task automatic run_stream(input int L, input int burst);
        int ia, ib, sa, sb, grp;
        logic pre_ov, pre_ordy, acc_a, acc_b, is_new;
        logic [4:0] e;
        logic [3:0] h_oa, h_ob;
        logic h_sel;
        do_reset();
        sbq.delete();
        ia = 0; ib = 0; sa = 0; sb = 0;
        h_oa = 4'h0; h_ob = 4'h0; h_sel = 1'b0;
        for (int k = 0; k < 16; k++) begin
            grp = k / burst;
            if (grp % 2 == 0) begin sbq.push_back({1'b0, a_val(ia)}); ia++; end
            else              begin sbq.push_back({1'b1, b_val(ib)}); ib++; end
        end
        for (int cyc = 0; cyc < 80 && sbq.size() > 0; cyc++) begin
            @(negedge clk);
            av[L] = 1'b1; ad[L] = a_val(sa);
            bv[L] = 1'b1; bd[L] = b_val(sb);
            ordy[L] = (cyc < 6) ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            if (cyc >= 2 && !ordy[L]) begin
                chk($sformatf("stall_a_ready L%0d", L), 16'(ar[L]), 16'h0);
                chk($sformatf("stall_b_ready L%0d", L), 16'(br[L]), 16'h0);
            end
            acc_a = ar[L]; acc_b = br[L];
            pre_ov = ov[L]; pre_ordy = ordy[L];
            @(posedge clk);
            #1;
            if (acc_a) sa++;
            if (acc_b) sb++;
            is_new = ov[L] && (!pre_ov || pre_ordy);
            if (is_new) begin
                e = sbq.pop_front();
                chk($sformatf("sb_sel L%0d", L), 16'(sel[L]), 16'(e[4]));
                chk($sformatf("sb_data L%0d", L),
                    16'(e[4] ? ob[L] : oa[L]), 16'(e[3:0]));
            end else if (ov[L]) begin
                chk($sformatf("hold_sel L%0d", L), 16'(sel[L]), 16'(h_sel));
                chk($sformatf("hold_a L%0d", L), 16'(oa[L]), 16'(h_oa));
                chk($sformatf("hold_b L%0d", L), 16'(ob[L]), 16'(h_ob));
            end
            h_oa = oa[L]; h_ob = ob[L]; h_sel = sel[L];
        end
        chk($sformatf("sb_left L%0d", L), 16'(sbq.size()), 16'h0);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // av ad bv bd ordy | ar br | ov sel oa ob
        vt[0]  = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};
        vt[1]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0};
        vt[2]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h0};
        vt[3]  = '{1'b0, 4'h0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h0};
        vt[4]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 4'h9};
        vt[5]  = '{1'b1, 4'h5, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 4'h9};
        vt[6]  = '{1'b1, 4'h6, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 4'h9};
        vt[7]  = '{1'b1, 4'h6, 1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 4'h9};
        vt[8]  = '{1'b1, 4'h7, 1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 4'hA};
        vt[9]  = '{1'b1, 4'h7, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 4'hA};
        vt[10] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 4'hB};
        vt[11] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h7, 4'hB};
        vt[12] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h7, 4'hB};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 16'(ov[0]), 16'h0);
        chk("rst_out_sel",   16'(sel[0]), 16'h0);
        chk("rst_out_a",     16'(oa[0]), 16'h0);
        chk("rst_out_b",     16'(ob[0]), 16'h0);
        chk("rst_a_ready",   16'(ar[0]), 16'h0);
        chk("rst_b_ready",   16'(br[0]), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_a_ready", 16'(ar[0]), 16'h1);
        chk("rel_b_ready", 16'(br[0]), 16'h1);

        // Cycle vector table on lane 0 (BURST=1)
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            av[0] = vt[i].av; ad[0] = vt[i].ad;
            bv[0] = vt[i].bv; bd[0] = vt[i].bd;
            ordy[0] = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d a_ready", i), 16'(ar[0]), 16'(vt[i].ar));
            chk($sformatf("vec%0d b_ready", i), 16'(br[0]), 16'(vt[i].br));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), 16'(ov[0]), 16'(vt[i].ov));
            chk($sformatf("vec%0d out_sel", i),   16'(sel[0]), 16'(vt[i].sel));
            chk($sformatf("vec%0d out_a", i),     16'(oa[0]), 16'(vt[i].oa));
            chk($sformatf("vec%0d out_b", i),     16'(ob[0]), 16'(vt[i].ob));
        end

        // Contention with backpressure, BURST=1 then BURST=2
        run_stream(0, 1);
        run_stream(1, 2);

        // Reset mid-operation with both buffers full and output held
        do_reset();
        @(negedge clk);
        av[0] = 1'b1; ad[0] = 4'h4; bv[0] = 1'b1; bd[0] = 4'h8; ordy[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_out_valid", 16'(ov[0]), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 16'(ov[0]), 16'h0);
        chk("mid_rst_out_a",     16'(oa[0]), 16'h0);
        chk("mid_rst_out_b",     16'(ob[0]), 16'h0);
        chk("mid_rst_out_sel",   16'(sel[0]), 16'h0);
        chk("mid_rst_a_ready",   16'(ar[0]), 16'h0);
        chk("mid_rst_b_ready",   16'(br[0]), 16'h0);
        @(negedge clk);
        idle_inputs();
        ordy[0] = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_a_ready", 16'(ar[0]), 16'h1);
        chk("post_rst_b_ready", 16'(br[0]), 16'h1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_replay", 16'(ov[0]), 16'h0);
        end

`ifdef BUS_SEL_STATS_EN
        // Saturation of the A handshake counter and synchronous clear
        do_reset();
        @(negedge clk);
        av[0] = 1'b1; ad[0] = 4'h3; ordy[0] = 1'b1;
        repeat (70010) @(posedge clk);
        @(negedge clk);
        av[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("stats_cnt_a_sat", cnt_a0, 16'hFFFF);
        chk("stats_cnt_b_zero", cnt_b0, 16'h0000);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("stats_cnt_a_clr", cnt_a0, 16'h0000);
        chk("stats_cnt_b_clr", cnt_b0, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
